// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped cache controller.
package cache_pkg;

    localparam int DEF_AWIDTH = 9;
    localparam int DEF_DWIDTH = 32;
    localparam int DEF_IDX_W  = 4;
    localparam int DEF_CNT_W  = 16;
    localparam int TAG_W      = DEF_AWIDTH - DEF_IDX_W;
    localparam int NLINES     = 1 << DEF_IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        CMP,
        MRD,
        MFILL,
        MWR,
        MWDONE
    } state_t;

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays for a direct-mapped cache: one combinational read
// port, one write port and a single-cycle invalidate of every line.
module cache_line_store #(
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 5,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DWIDTH-1:0] rd_data,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_set_valid,
    input  logic              clear_all
);

    localparam int NL = 1 << IDX_W;

    logic [NL-1:0]     valid;
    logic [TAG_W-1:0]  tag_mem  [NL];
    logic [DWIDTH-1:0] data_mem [NL];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

    // Only the valid bits need a reset; tag/data are qualified by them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (clear_all) begin
            valid <= '0;
        end else if (we && wr_set_valid) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// saturating hit/miss counters and whole-cache flush.
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic [DWIDTH-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              flush,
    output logic              rd_mem,
    output logic              wr_mem,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              ready_mem,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int LTAG_W = AWIDTH - IDX_W;

    state_t state, next_state;

    logic              req_we;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic              flush_pend;
    logic              accept;

    logic [IDX_W-1:0]  req_idx;
    logic [LTAG_W-1:0] req_tag;
    logic              rd_valid;
    logic [LTAG_W-1:0] rd_tag;
    logic [DWIDTH-1:0] rd_data;
    logic              line_hit;
    logic              st_we;
    logic [DWIDTH-1:0] st_data;
    logic              clear_all;

    assign req_idx   = req_addr[IDX_W-1:0];
    assign req_tag   = req_addr[AWIDTH-1:IDX_W];
    assign line_hit  = rd_valid && (rd_tag == req_tag);
    assign st_data   = req_we ? req_wdata : mem_rdata;
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;

    cache_line_store #(
        .IDX_W (IDX_W),
        .TAG_W (LTAG_W),
        .DWIDTH(DWIDTH)
    ) u_store (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_idx      (req_idx),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .we          (st_we),
        .wr_idx      (req_idx),
        .wr_tag      (req_tag),
        .wr_data     (st_data),
        .wr_set_valid(1'b1),
        .clear_all   (clear_all)
    );

    always_comb begin
        next_state = state;
        rd_mem     = 1'b0;
        wr_mem     = 1'b0;
        st_we      = 1'b0;
        clear_all  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                // A flush always wins over a waiting request.
                if (flush || flush_pend) begin
                    clear_all = 1'b1;
                end else if (cpu_req && !cpu_ack) begin
                    accept     = 1'b1;
                    next_state = CMP;
                end
            end
            CMP: begin
                if (req_we)        next_state = MWR;
                else if (line_hit) next_state = IDLE;
                else               next_state = MRD;
            end
            MRD: begin
                rd_mem     = 1'b1;
                next_state = MFILL;
            end
            MFILL: begin
                st_we      = 1'b1;
                next_state = IDLE;
            end
            MWR: begin
                wr_mem     = 1'b1;
                st_we      = line_hit;
                next_state = MWDONE;
            end
            MWDONE: begin
                if (ready_mem) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            flush_pend <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            state   <= next_state;
            cpu_ack <= (state == CMP && !req_we && line_hit) ||
                       (state == MFILL) ||
                       (state == MWDONE && ready_mem);
            if (accept) begin
                req_we    <= cpu_we;
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
            end
            if (state == IDLE)  flush_pend <= 1'b0;
            else if (flush)     flush_pend <= 1'b1;
            if (state == CMP && !req_we && line_hit) cpu_rdata <= rd_data;
            else if (state == MFILL)                 cpu_rdata <= mem_rdata;
            // Counters stick at all-ones rather than wrapping.
            if (state == CMP && !req_we) begin
                if (line_hit) begin
                    if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                end else begin
                    if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: behavioural memory, reference cache
// model, directed scenarios followed by randomized traffic.
module tb_dm_cache_ctrl;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int CW  = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          flush = 1'b0;
    logic          rd_mem, wr_mem;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          ready_mem = 1'b1;
    logic [CW-1:0] hit_cnt, miss_cnt;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem     [512];
    logic [DW-1:0] ref_mem [512];
    bit            ref_valid [16];
    int            ref_tag   [16];
    int            ref_hits = 0;
    int            ref_misses = 0;
    int            stall = 0;
    int            last_stall = 0;

    always #5 clk = ~clk;

    dm_cache_ctrl #(
        .AWIDTH(AW), .DWIDTH(DW), .IDX_W(4), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .flush(flush), .rd_mem(rd_mem), .wr_mem(wr_mem),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ready_mem(ready_mem), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Memory acts on the falling edge; after a write it stays busy for a
    // random number of cycles.
    always @(negedge clk) begin
        if (wr_mem) begin
            mem[mem_addr] = mem_wdata;
            stall = int'($urandom_range(0, 2));
            last_stall = stall;
        end else if (stall > 0) begin
            ready_mem = 1'b0;
            stall--;
        end else begin
            ready_mem = 1'b1;
        end
        mem_rdata = mem[mem_addr];
    end

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                               input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input bit flush_fill);
        int a, idx, tag, edges, rd_pulses, wr_pulses, exp_lat;
        bit hit, acked, addr_ok, data_ok;
        logic [DW-1:0] got, exp_data;
        a   = int'(addr);
        idx = a % 16;
        tag = a / 16;
        hit = !we && ref_valid[idx] && ref_tag[idx] == tag;
        exp_data = ref_mem[a];
        edges = 0; rd_pulses = 0; wr_pulses = 0;
        acked = 1'b0; addr_ok = 1'b1; data_ok = 1'b1; got = '0;

        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        while (!acked && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (rd_mem && wr_mem) data_ok = 1'b0;
            if (rd_mem) begin
                rd_pulses++;
                if (mem_addr !== addr) addr_ok = 1'b0;
                if (flush_fill) begin
                    @(negedge clk);
                    flush = 1'b1;
                end
            end
            if (wr_mem) begin
                wr_pulses++;
                if (mem_addr !== addr || mem_wdata !== wdata) addr_ok = 1'b0;
            end
            if (cpu_ack) begin
                acked = 1'b1;
                got = cpu_rdata;
            end
        end
        @(negedge clk);
        cpu_req = 1'b0;
        flush   = 1'b0;

        // Reference update from the cache's architectural rules.
        if (we) begin
            ref_mem[a] = wdata;
            exp_lat = 4 + last_stall;
        end else if (hit) begin
            ref_hits++;
            exp_lat = 2;
        end else begin
            ref_misses++;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tag;
            exp_lat = 4;
            if (flush_fill) for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        end

        checkOutput("ack_seen", 32'(acked), 32'd1);
        checkOutput("latency", 32'(edges), 32'(exp_lat));
        checkOutput("rd_pulses", 32'(rd_pulses), (!we && !hit) ? 32'd1 : 32'd0);
        checkOutput("wr_pulses", 32'(wr_pulses), we ? 32'd1 : 32'd0);
        checkOutput("mem_port", 32'(addr_ok), 32'd1);
        checkOutput("strobe_excl", 32'(data_ok), 32'd1);
        if (!we) checkOutput("rdata", got, exp_data);
        else     checkOutput("mem_written", mem[a], wdata);
        checkOutput("hit_cnt", 32'(hit_cnt), 32'(sat(ref_hits)));
        checkOutput("miss_cnt", 32'(miss_cnt), 32'(sat(ref_misses)));
        @(posedge clk); #1;
        checkOutput("ack_one_cycle", 32'(cpu_ack), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ack"}, 32'(cpu_ack), 32'd0);
        checkOutput({tag, "_rdata"}, cpu_rdata, 32'd0);
        checkOutput({tag, "_rd_mem"}, 32'(rd_mem), 32'd0);
        checkOutput({tag, "_wr_mem"}, 32'(wr_mem), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_hit_cnt"}, 32'(hit_cnt), 32'd0);
        checkOutput({tag, "_miss_cnt"}, 32'(miss_cnt), 32'd0);
    endtask

    initial begin
        int waited, acks;
        bit seen;
        for (int i = 0; i < 512; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[9'h013] = 32'hDEADBEEF;
        ref_mem[9'h013] = 32'hDEADBEEF;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] directed: cold/repeat/conflict reads");
        applyStimulus(1'b0, 9'h013, '0, 1'b0);
        applyStimulus(1'b0, 9'h013, '0, 1'b0);
        applyStimulus(1'b0, 9'h023, '0, 1'b0);
        applyStimulus(1'b0, 9'h013, '0, 1'b0);
        checkOutput("conflict_miss_cnt", 32'(miss_cnt), 32'd3);

        $display("[TB] directed: writes");
        applyStimulus(1'b1, 9'h013, 32'h12345678, 1'b0);
        applyStimulus(1'b0, 9'h013, '0, 1'b0);
        checkOutput("write_hit_data", cpu_rdata, 32'h12345678);
        applyStimulus(1'b1, 9'h044, 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b0, 9'h044, '0, 1'b0);

        $display("[TB] directed: flush during fill");
        applyStimulus(1'b0, 9'h155, '0, 1'b1);
        applyStimulus(1'b0, 9'h013, '0, 1'b0);

        $display("[TB] directed: reset in MRD");
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h1A7;
        seen = 1'b0; waited = 0; acks = 0;
        while (!seen && waited < 10) begin
            @(posedge clk); #1;
            waited++;
            if (cpu_ack) acks++;
            if (rd_mem) seen = 1'b1;
        end
        checkOutput("reached_mrd", 32'(seen), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        if (cpu_ack) acks++;
        checkAllZero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (cpu_ack) acks++;
        end
        checkOutput("no_ack_after_abort", 32'(acks), 32'd0);
        modelReset();

        $display("[TB] random traffic");
        for (int n = 0; n < 150; n++) begin
            int t, ix, av;
            t  = int'($urandom_range(0, 2));
            ix = int'($urandom_range(0, 3));
            av = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 511)) : t * 16 + ix;
            applyStimulus(1'($urandom_range(0, 2) == 0), AW'(av), $urandom,
                          1'($urandom_range(0, 9) == 0));
        end

        $display("[TB] counter saturation");
        applyStimulus(1'b0, 9'h0AF, '0, 1'b0);
        for (int n = 0; n < CNT_MAX + 3; n++) applyStimulus(1'b0, 9'h0AF, '0, 1'b0);
        checkOutput("hit_saturated", 32'(hit_cnt), 32'(CNT_MAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
